// File: rtl/spi_fifo_wm.sv
// SPI TX/RX queue: req/ack write port, req/resp/ack read port, flush, sticky overflow/underflow status.
// Watermark outputs are compiled in only when SPI_FIFO_WATERMARK_EN is defined; otherwise they are tied low.
module spi_fifo_wm #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_ADDR  = 4,
  parameter int REG_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  allow_overwrite_i,
  input  logic                  clr_status_i,
  input  logic [FIFO_ADDR:0]    af_thr_i,
  input  logic [FIFO_ADDR:0]    ae_thr_i,
  input  logic                  req_a_i,
  input  logic [DATA_WIDTH-1:0] data_a_i,
  output logic                  ack_a_o,
  input  logic                  req_b_i,
  output logic [DATA_WIDTH-1:0] data_b_o,
  output logic                  resp_b_o,
  input  logic                  ack_b_i,
  output logic [REG_WIDTH-1:0]  fifo_occupancy_o,
  output logic                  fifo_full_o,
  output logic                  fifo_empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  typedef enum logic {WR_IDLE, WR_ACK} wr_state_e;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

  localparam logic [FIFO_ADDR:0]   DEPTH_C = (FIFO_ADDR+1)'(FIFO_DEPTH);
  localparam logic [FIFO_ADDR:0]   OCC_ONE = (FIFO_ADDR+1)'(1);
  localparam logic [FIFO_ADDR-1:0] PTR_ONE = FIFO_ADDR'(1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_ADDR-1:0]  head_q, head_d, tail_q, tail_d;
  logic [FIFO_ADDR:0]    occ_q, occ_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  wr_state_e             wr_state_q, wr_state_d;
  rd_state_e             rd_state_q, rd_state_d;
  logic                  full, empty, wr_acc, rd_acc, ovf_ev, udf_ev;

  always_comb begin
    full   = (occ_q == DEPTH_C);
    empty  = (occ_q == '0);
    rd_acc = !flush_i && (rd_state_q == RD_IDLE) && req_b_i && !empty;
    // A full queue still takes a write when a read frees a slot in the same edge.
    wr_acc = !flush_i && (wr_state_q == WR_IDLE) && req_a_i &&
             (!full || rd_acc || allow_overwrite_i);
    ovf_ev = !flush_i && (wr_state_q == WR_IDLE) && req_a_i && !wr_acc;
    udf_ev = !flush_i && (rd_state_q == RD_IDLE) && req_b_i && empty;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      data_q     <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_acc) begin
      mem_q[tail_q] <= data_a_i;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    if (flush_i) begin
      wr_state_d = WR_IDLE;
      rd_state_d = RD_IDLE;
    end else begin
      case (wr_state_q)
        WR_IDLE: if (wr_acc) wr_state_d = WR_ACK;
        default: wr_state_d = WR_IDLE;
      endcase
      case (rd_state_q)
        RD_IDLE: if (rd_acc) rd_state_d = RD_RESP;
        default: if (ack_b_i) rd_state_d = RD_IDLE;
      endcase
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    data_d = data_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
      data_d = '0;
    end else begin
      if (wr_acc) tail_d = tail_q + PTR_ONE;
      // Overwrite on a full queue drops the oldest word; a paired read already advances head.
      if (rd_acc || (wr_acc && full)) head_d = head_q + PTR_ONE;
      if (wr_acc && !rd_acc && !full) occ_d = occ_q + OCC_ONE;
      else if (rd_acc && !wr_acc) occ_d = occ_q - OCC_ONE;
      if (rd_acc) data_d = mem_q[head_q];
      ovf_d = ovf_ev || (ovf_q && !clr_status_i);
      udf_d = udf_ev || (udf_q && !clr_status_i);
    end
  end

  always_comb begin
    ack_a_o          = (wr_state_q == WR_ACK);
    resp_b_o         = (rd_state_q == RD_RESP);
    data_b_o         = data_q;
    fifo_occupancy_o = '0;
    fifo_occupancy_o[FIFO_ADDR:0] = occ_q;
    fifo_full_o      = full;
    fifo_empty_o     = empty;
    overflow_o       = ovf_q;
    underflow_o      = udf_q;
  end

`ifdef SPI_FIFO_WATERMARK_EN
  assign almost_full_o  = (occ_q >= af_thr_i);
  assign almost_empty_o = (occ_q <= ae_thr_i);
`else
  logic unused_thr;
  assign unused_thr     = ^{af_thr_i, ae_thr_i};
  assign almost_full_o  = 1'b0;
  assign almost_empty_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_fifo_wm.sv
// Randomized bench for spi_fifo_wm (depth 4): a queue-based reference model predicts every output each cycle.
module tb_spi_fifo_wm;
  localparam int DW = 16, DEPTH = 4, AW = 2, RW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1, flush_i = 1'b0, allow_overwrite_i = 1'b0, clr_status_i = 1'b0;
  logic [AW:0]   af_thr_i = 3'd3, ae_thr_i = 3'd1;
  logic          req_a_i = 1'b0, req_b_i = 1'b0, ack_b_i = 1'b0;
  logic [DW-1:0] data_a_i = '0;
  logic          ack_a_o, resp_b_o, fifo_full_o, fifo_empty_o;
  logic          almost_full_o, almost_empty_o, overflow_o, underflow_o;
  logic [DW-1:0] data_b_o;
  logic [RW-1:0] fifo_occupancy_o;

  always #5 clk_i = ~clk_i;

  spi_fifo_wm #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FIFO_ADDR(AW), .REG_WIDTH(RW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .allow_overwrite_i(allow_overwrite_i),
    .clr_status_i(clr_status_i), .af_thr_i(af_thr_i), .ae_thr_i(ae_thr_i),
    .req_a_i(req_a_i), .data_a_i(data_a_i), .ack_a_o(ack_a_o),
    .req_b_i(req_b_i), .data_b_o(data_b_o), .resp_b_o(resp_b_o), .ack_b_i(ack_b_i),
    .fifo_occupancy_o(fifo_occupancy_o), .fifo_full_o(fifo_full_o), .fifo_empty_o(fifo_empty_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: the queue contents plus what each handshake port is currently showing.
  logic [DW-1:0] q[$];
  bit            m_ack, m_resp, m_ovf, m_udf;
  logic [DW-1:0] m_data;

  task automatic check_outputs();
    int n;
    n = q.size();
    check("occupancy", fifo_occupancy_o, n);
    check("full", fifo_full_o, n == DEPTH);
    check("empty", fifo_empty_o, n == 0);
    check("ack_a", ack_a_o, m_ack);
    check("resp_b", resp_b_o, m_resp);
    check("data_b", data_b_o, m_data);
    check("overflow", overflow_o, m_ovf);
    check("underflow", underflow_o, m_udf);
`ifdef SPI_FIFO_WATERMARK_EN
    check("almost_full", almost_full_o, n >= int'(af_thr_i));
    check("almost_empty", almost_empty_o, n <= int'(ae_thr_i));
`else
    check("almost_full", almost_full_o, 1'b0);
    check("almost_empty", almost_empty_o, 1'b0);
`endif
  endtask

  task automatic model_step();
    bit is_full, is_empty, rd, wr, ovf_ev, udf_ev;
    if (rst_i) begin
      q.delete();
      m_ack = 0; m_resp = 0; m_data = '0; m_ovf = 0; m_udf = 0;
    end else if (flush_i) begin
      q.delete();
      m_ack = 0; m_resp = 0; m_data = '0;
    end else begin
      is_full  = (q.size() == DEPTH);
      is_empty = (q.size() == 0);
      rd       = !m_resp && req_b_i && !is_empty;
      wr       = !m_ack && req_a_i && (!is_full || rd || allow_overwrite_i);
      ovf_ev   = !m_ack && req_a_i && !wr;
      udf_ev   = !m_resp && req_b_i && is_empty;
      if (rd) begin
        m_data = q.pop_front();
        m_resp = 1;
      end else if (m_resp && ack_b_i) begin
        m_resp = 0;
      end
      if (wr) begin
        if (q.size() == DEPTH) void'(q.pop_front());
        q.push_back(data_a_i);
      end
      m_ack = wr;
      m_ovf = ovf_ev || (m_ovf && !clr_status_i);
      m_udf = udf_ev || (m_udf && !clr_status_i);
    end
  endtask

  // Phases: write-heavy, read-heavy, balanced, overwrite-heavy.
  int pa[4] = '{75, 25, 50, 80};
  int pb[4] = '{30, 75, 50, 60};
  int po[4] = '{10,  0, 20, 70};

  initial begin
    q.delete();
    m_ack = 0; m_resp = 0; m_data = '0; m_ovf = 0; m_udf = 0;
    model_step();
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 600; c++) begin
        @(negedge clk_i);
        check_outputs();
        rst_i             = ($urandom_range(0, 249) == 0);
        flush_i           = !rst_i && ($urandom_range(0, 59) == 0);
        clr_status_i      = !flush_i && ($urandom_range(0, 7) == 0);
        req_a_i           = ($urandom_range(0, 99) < pa[ph]);
        req_b_i           = ($urandom_range(0, 99) < pb[ph]);
        ack_b_i           = ($urandom_range(0, 1) == 1);
        allow_overwrite_i = ($urandom_range(0, 99) < po[ph]);
        data_a_i          = DW'($urandom);
        if ($urandom_range(0, 49) == 0) af_thr_i = AW'(0) + 3'($urandom_range(0, DEPTH));
        if ($urandom_range(0, 49) == 0) ae_thr_i = 3'($urandom_range(0, DEPTH));
        model_step();
      end
    end
    @(negedge clk_i);
    check_outputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
